// File: rtl/irq_ctrl_pkg.sv
// Shared types and helpers for the irq_ctrl interrupt controller.
package irq_ctrl_pkg;

   typedef enum logic [1:0] {IDLE, ASSERT, BUSY, GAP} state_t;

   // Shortest irq low time that still gives the CPU synchronizer a clean edge.
   localparam int MIN_LOW_LB = 3;

   function automatic int id_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// Handler-side request/claim/complete handshake of irq_ctrl.
interface irq_ctrl_if #(
   parameter int ID_W = 3
) ();

   logic            irq;
   logic            claim_valid;
   logic [ID_W-1:0] claim_id;
   logic            claim;
   logic            complete;
   logic [ID_W-1:0] complete_id;

   modport slave (
      input  claim, complete, complete_id,
      output irq, claim_valid, claim_id
   );

   modport master (
      output claim, complete, complete_id,
      input  irq, claim_valid, claim_id
   );

endinterface

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder: any request set, and the index of the winner.
module irq_prio_enc #(
   parameter int N = 8,
   parameter int W = 3
) (
   input  logic [N-1:0] req,
   output logic         any,
   output logic [W-1:0] id
);

   always_comb begin
      any = 1'b0;
      id  = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            any = 1'b1;
            id  = W'(i);
         end
      end
   end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: latches source requests, presents one to the CPU and runs claim/complete.
// Build option IRQ_CTRL_LEVEL_EN selects level-sensitive sources instead of edge capture.
//
// state  | meaning
// IDLE   | waiting for an enabled pending source
// ASSERT | irq high, sel_id presented, waiting for claim
// BUSY   | handler servicing claim_id, irq low
// GAP    | enforced irq low time counting down before IDLE
module irq_ctrl
   import irq_ctrl_pkg::*;
#(
   parameter int NUM_SRC = 8,
   parameter int ID_W    = id_w(NUM_SRC),
   parameter int MIN_LOW = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_SRC-1:0] src,
   input  logic [NUM_SRC-1:0] en_mask,
   irq_ctrl_if.slave          bus,
   output logic [NUM_SRC-1:0] pending
);

   localparam int              LOW_CYC  = (MIN_LOW < MIN_LOW_LB) ? MIN_LOW_LB : MIN_LOW;
   localparam int              CNT_W    = $clog2(LOW_CYC);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOW_CYC - 1);

   state_t             state, state_d;
   logic [ID_W-1:0]    sel_id, sel_id_d, claim_id_d, pick_id;
   logic               irq_d, claim_valid_d, pick_any, take_claim;
   logic [CNT_W-1:0]   cnt, cnt_d;
   logic [NUM_SRC-1:0] req;

   assign take_claim = (state == ASSERT) && bus.claim;
   assign req        = pending & en_mask;

   irq_prio_enc #(.N(NUM_SRC), .W(ID_W)) u_prio (
      .req (req),
      .any (pick_any),
      .id  (pick_id)
   );

`ifdef IRQ_CTRL_LEVEL_EN
   logic [NUM_SRC-1:0] svc_mask;

   always_comb begin
      svc_mask = '0;
      if (state == BUSY) svc_mask[bus.claim_id] = 1'b1;
   end

   assign pending = src & en_mask & ~svc_mask;
`else
   logic [NUM_SRC-1:0] src_prev, edge_set, clr_mask;

   always_comb begin
      clr_mask = '0;
      if (take_claim) clr_mask[sel_id] = 1'b1;
   end

   assign edge_set = src & ~src_prev & en_mask;

   // Set is OR-ed after the clear so a coincident new edge survives the claim.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         src_prev <= '0;
         pending  <= '0;
      end else begin
         src_prev <= src;
         pending  <= (pending & ~clr_mask) | edge_set;
      end
   end
`endif

   always_comb begin
      state_d       = state;
      sel_id_d      = sel_id;
      claim_id_d    = bus.claim_id;
      irq_d         = bus.irq;
      claim_valid_d = 1'b0;
      cnt_d         = cnt;
      unique case (state)
         IDLE: begin
            if (pick_any) begin
               sel_id_d = pick_id;
               irq_d    = 1'b1;
               state_d  = ASSERT;
            end
         end
         ASSERT: begin
            if (take_claim) begin
               irq_d         = 1'b0;
               claim_id_d    = sel_id;
               claim_valid_d = 1'b1;
               state_d       = BUSY;
            end else if (!en_mask[sel_id]) begin
               // Withdrawn request still needs a full low gap before the next one.
               irq_d   = 1'b0;
               cnt_d   = CNT_LOAD;
               state_d = GAP;
            end
         end
         BUSY: begin
            irq_d = 1'b0;
            if (bus.complete && (bus.complete_id == bus.claim_id)) begin
               cnt_d   = CNT_LOAD;
               state_d = GAP;
            end
         end
         GAP: begin
            irq_d = 1'b0;
            if (cnt == '0) state_d = IDLE;
            else           cnt_d   = cnt - 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         sel_id          <= '0;
         cnt             <= '0;
         bus.irq         <= 1'b0;
         bus.claim_valid <= 1'b0;
         bus.claim_id    <= '0;
      end else begin
         state           <= state_d;
         sel_id          <= sel_id_d;
         cnt             <= cnt_d;
         bus.irq         <= irq_d;
         bus.claim_valid <= claim_valid_d;
         bus.claim_id    <= claim_id_d;
      end
   end

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl (edge mode): directed steps then random traffic vs. a timeline model.
module tb_irq_ctrl;
   import irq_ctrl_pkg::*;

   localparam int NUM_SRC = 8;
   localparam int ID_W    = 3;
   localparam int MIN_LOW = 4;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic [NUM_SRC-1:0] src, en_mask, pending;

   irq_ctrl_if #(.ID_W(ID_W)) bus ();

   irq_ctrl #(.NUM_SRC(NUM_SRC), .ID_W(ID_W), .MIN_LOW(MIN_LOW)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .src     (src),
      .en_mask (en_mask),
      .bus     (bus),
      .pending (pending)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model: who is presented, who is in service, and an absolute
   // edge number before which no new request may be presented.
   bit m_pend [NUM_SRC];
   bit m_prev [NUM_SRC];
   int m_present, m_service, m_block_until, m_cyc, m_cid;
   bit m_irq, m_cv;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] m_pend_vec();
      logic [31:0] v = '0;
      for (int i = 0; i < NUM_SRC; i++) v[i] = m_pend[i];
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NUM_SRC; i++) begin
         m_pend[i] = 1'b0;
         m_prev[i] = 1'b0;
      end
      m_present = -1; m_service = -1; m_block_until = -1; m_cyc = 0;
      m_cid = 0; m_irq = 1'b0; m_cv = 1'b0;
   endtask

   task automatic model_step();
      bit set_now [NUM_SRC];
      int clr;
      m_cyc++;
      clr  = -1;
      m_cv = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) set_now[i] = src[i] && !m_prev[i] && en_mask[i];
      if (m_present >= 0) begin
         if (bus.claim) begin
            clr = m_present; m_cid = m_present; m_cv = 1'b1;
            m_service = m_present; m_present = -1; m_irq = 1'b0;
         end else if (!en_mask[m_present]) begin
            m_present = -1; m_irq = 1'b0; m_block_until = m_cyc + MIN_LOW;
         end
      end else if (m_service >= 0) begin
         if (bus.complete && int'(bus.complete_id) == m_service) begin
            m_service = -1; m_block_until = m_cyc + MIN_LOW;
         end
      end else if (m_cyc > m_block_until) begin
         for (int i = 0; i < NUM_SRC; i++) begin
            if (m_present < 0 && m_pend[i] && en_mask[i]) begin
               m_present = i; m_irq = 1'b1;
            end
         end
      end
      for (int i = 0; i < NUM_SRC; i++) begin
         m_pend[i] = (m_pend[i] && i != clr) || set_now[i];
         m_prev[i] = src[i];
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check("irq",         32'(bus.irq),         32'(m_irq));
      check("claim_valid", 32'(bus.claim_valid), 32'(m_cv));
      check("claim_id",    32'(bus.claim_id),    32'(m_cid));
      check("pending",     32'(pending),         m_pend_vec());
   endtask

   initial begin
      int lows;
      src = '0; en_mask = '1;
      bus.claim = 1'b0; bus.complete = 1'b0; bus.complete_id = '0;
      model_reset();
      repeat (3) @(negedge clk);
      check("rst_irq",  32'(bus.irq),         32'd0);
      check("rst_cv",   32'(bus.claim_valid), 32'd0);
      check("rst_cid",  32'(bus.claim_id),    32'd0);
      check("rst_pend", 32'(pending),         32'd0);
      rst_n = 1'b1;

      // Edge on src[3], presentation latency, claim.
      src = 8'h08; cycle();
      check("t1_pend_set", 32'(pending), 32'h08);
      check("t1_irq_lat1", 32'(bus.irq), 32'd0);
      src = 8'h00; cycle();
      check("t1_irq_lat2", 32'(bus.irq), 32'd1);
      bus.claim = 1'b1; cycle();
      check("t1_cv",   32'(bus.claim_valid), 32'd1);
      check("t1_cid",  32'(bus.claim_id),    32'd3);
      check("t1_pclr", 32'(pending),         32'h00);
      bus.claim = 1'b0; src = 8'h01; cycle();
      check("t1_cv_end", 32'(bus.claim_valid), 32'd0);

      // Mismatched complete keeps BUSY; stray claim in GAP is ignored.
      src = 8'h00; bus.complete = 1'b1; bus.complete_id = 3'd4; cycle();
      bus.complete = 1'b0;
      repeat (6) cycle();
      check("t4_busy_hold", 32'(bus.irq), 32'd0);
      bus.complete = 1'b1; bus.complete_id = 3'd3; cycle();
      bus.complete = 1'b0; bus.claim = 1'b1; cycle();
      check("t4_gap_claim", 32'(bus.claim_valid), 32'd0);
      bus.claim = 1'b0;
      repeat (3) cycle();
      check("t4_gap_low", 32'(bus.irq), 32'd0);
      cycle();
      check("t4_rearm", 32'(bus.irq), 32'd1);
      bus.claim = 1'b1; cycle();
      check("t4_cid0", 32'(bus.claim_id), 32'd0);
      bus.claim = 1'b0; bus.complete = 1'b1; bus.complete_id = 3'd0; cycle();
      bus.complete = 1'b0;
      repeat (6) cycle();

      // Priority between src[5] and src[2], and the low gap length.
      src = 8'h24; cycle();
      src = 8'h00; cycle();
      bus.claim = 1'b1; cycle();
      check("t2_cid2", 32'(bus.claim_id), 32'd2);
      bus.claim = 1'b0; bus.complete = 1'b1; bus.complete_id = 3'd2; cycle();
      bus.complete = 1'b0;
      lows = 0;
      while (!bus.irq && lows < 20) begin
         cycle();
         lows++;
      end
      check("t2_gap_len", 32'(lows), 32'(MIN_LOW + 1));
      bus.claim = 1'b1; cycle();
      check("t2_cid5", 32'(bus.claim_id), 32'd5);
      bus.claim = 1'b0; bus.complete = 1'b1; bus.complete_id = 3'd5; cycle();
      bus.complete = 1'b0;
      repeat (6) cycle();

      // Masked edge is dropped and unmasking does not resurrect it.
      en_mask = 8'hFD; src = 8'h02; cycle();
      check("t3_masked", 32'(pending), 32'h00);
      src = 8'h00; cycle();
      en_mask = 8'hFF;
      repeat (3) cycle();
      check("t3_no_irq", 32'(bus.irq), 32'd0);

      // Mask drop before claim withdraws irq but keeps the pending bit.
      src = 8'h10; cycle();
      src = 8'h00; cycle();
      en_mask = 8'hEF; cycle();
      check("t6_withdraw", 32'(bus.irq), 32'd0);
      check("t6_keep",     32'(pending), 32'h10);
      en_mask = 8'hFF;
      repeat (MIN_LOW + 1) cycle();
      check("t6_reassert", 32'(bus.irq), 32'd1);
      bus.claim = 1'b1; cycle();
      bus.claim = 1'b0; bus.complete = 1'b1; bus.complete_id = 3'd4; cycle();
      bus.complete = 1'b0;
      repeat (6) cycle();

      // Set/clear collision, then asynchronous reset while BUSY.
      src = 8'h08; cycle();
      src = 8'h00; cycle();
      bus.claim = 1'b1; src = 8'h08; cycle();
      check("t5_collide", 32'(pending), 32'h08);
      bus.claim = 1'b0; src = 8'h00; cycle();
      #2 rst_n = 1'b0;
      #1;
      check("t5_rst_irq",  32'(bus.irq),         32'd0);
      check("t5_rst_cv",   32'(bus.claim_valid), 32'd0);
      check("t5_rst_cid",  32'(bus.claim_id),    32'd0);
      check("t5_rst_pend", 32'(pending),         32'd0);
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Random traffic against the model.
      for (int n = 0; n < 1500; n++) begin
         src = src ^ (NUM_SRC'($urandom) & NUM_SRC'($urandom) & NUM_SRC'($urandom));
         if ($urandom_range(0, 19) == 0)     en_mask = NUM_SRC'($urandom);
         else if ($urandom_range(0, 9) == 0) en_mask = '1;
         bus.claim = (m_present >= 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
         bus.complete = (m_service >= 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
         if (m_service >= 0 && $urandom_range(0, 3) != 0) bus.complete_id = ID_W'(m_service);
         else                                              bus.complete_id = ID_W'($urandom);
         cycle();
      end
      bus.claim = 1'b0; bus.complete = 1'b0;
      cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Peripheral-side interrupt controller that drives the CPU's single interrupt request line. It collects up to NUM_SRC peripheral interrupt sources and latches them as pending. It presents the highest-priority enabled source to the CPU as an `irq` pulse/level, then runs a claim/complete handshake with the trap handler. Between interrupts it holds `irq` low long enough for the CPU-side synchronizer and edge detector to see every new request as a fresh rising edge.

## Interface
- `NUM_SRC`, 8: number of interrupt sources, 1..32.
- `ID_W`, `$clog2(NUM_SRC)` (minimum 1): width of source IDs.
- `MIN_LOW`, 4: cycles `irq` is held low after a completion before it may rise again; minimum 3.

Ports:
- `clk` in 1: system clock. The only clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `src` in NUM_SRC: peripheral interrupt lines, synchronous to `clk`.
- `en_mask` in NUM_SRC: per-source enable, 1 = enabled.
- `claim` in 1: one-cycle pulse; the handler claims the presented interrupt.
- `complete` in 1: one-cycle pulse; the handler has finished servicing `complete_id`.
- `complete_id` in ID_W: ID being completed.
- `irq` out 1: interrupt request to the CPU, registered.
- `claim_valid` out 1: one-cycle pulse; `claim_id` is valid.
- `claim_id` out ID_W: ID of the in-service source. Registered; held from claim until complete.
- `pending` out NUM_SRC: pending bits, for debug/CSR readback.

## Operation
- Reset values: `irq`=0, `claim_valid`=0, `claim_id`=0, `pending`=0, state IDLE, gap counter 0.
- Source capture (default, edge mode):
  - `pending[i]` sets on a rising edge of `src[i]` (`src[i]` & ~`src_prev[i]`) while `en_mask[i]`=1.
  - Edges that occur while the source is masked are dropped.
- Selection: combinational priority pick over `pending & en_mask`; the lowest index wins.
- State IDLE:
  - If any enabled source is pending, latch the selected ID into `sel_id`, set `irq`=1, go to ASSERT.
- State ASSERT:
  - On `claim`: clear `pending[sel_id]`, `irq`=0, `claim_id`=`sel_id`, pulse `claim_valid` for one cycle, go to BUSY.
  - If `en_mask[sel_id]` drops before a claim: `irq`=0, go to GAP. The pending bit is retained.
- State BUSY:
  - `irq` stays 0.
  - `complete` with `complete_id`==`claim_id` → go to GAP and load the counter with MIN_LOW−1.
  - A `complete` with a mismatched ID is ignored.
  - New edges keep setting pending bits in this state.
- State GAP:
  - `irq`=0; decrement the counter; at 0, go to IDLE.
- `claim` outside ASSERT is ignored: no `claim_valid`, no state change.
- `complete` outside BUSY is ignored.
- Simultaneous events:
  - A source edge in the same cycle its pending bit is cleared by a claim: set wins, so the bit stays 1.
  - `claim` in the same cycle the mask drops: the claim wins.
- Any `rst_n` low mid-handshake returns everything to the reset values immediately; pending interrupts are lost.

## Timing
- `src` rise at edge N → `pending` set at edge N+1 → `irq` high at edge N+2, giving 2-cycle latency.
- `claim` sampled at edge K → `irq` low and `claim_valid` high after edge K; `claim_valid` low after edge K+1.
- `complete` sampled at edge C → `irq` held low through at least edge C+MIN_LOW. The earliest re-assert is at edge C+MIN_LOW+1.
- Guaranteed minimum `irq` low time between two requests is MIN_LOW+1 cycles. This covers the CPU's 2-flop synchronizer plus its previous-value register.

## Configuration
- `IRQ_CTRL_LEVEL_EN`:
  - Defined: sources are level-sensitive. `pending[i]` is `src[i]` & `en_mask[i]` & ~(in service and `claim_id`==i). A source still high at complete re-requests after the GAP. There is no edge detector and no `src_prev` register.
  - Undefined: edge mode as described in Operation.

## Structure
- Package `irq_ctrl_pkg`:
  - State enum {IDLE, ASSERT, BUSY, GAP}.
  - MIN_LOW lower-bound constant (3).
  - `id_w(n)` width helper.
- Sub-module `irq_prio_enc`: parameterized lowest-index-first priority encoder. Outputs `any` and `id`.

## Test plan
- Edge, mask, and claim: `en_mask`=0xFF, pulse `src[3]` one cycle → `irq`=1 two cycles later. Then `claim` → `claim_valid` pulse with `claim_id`=3, `irq`=0, `pending[3]`=0.
- Priority: `src[5]` and `src[2]` rise together → `claim_id`=2. After `complete`(2) and MIN_LOW=4 low cycles, `irq` re-rises → claim gives `claim_id`=5.
- Masked source: `en_mask[1]`=0 and `src[1]` rises → `pending[1]` stays 0 and `irq` stays 0. Unmasking afterward does not raise `irq`.
- Wrong complete and stray claim:
  - `complete_id`=4 while servicing ID 3 → state stays BUSY.
  - `claim` during GAP → no `claim_valid`.
- Set/clear collision and reset: `src[3]` rises in the same cycle `claim` clears `pending[3]` → `pending[3]`=1. Then assert `rst_n`=0 during BUSY → all outputs 0 asynchronously.
